// File: rtl/ula_nibble_seq.sv
// Multi-nibble sequencer: runs a 4*NIBBLES-bit operation through an external
// 4-bit ula_74181 slice, one nibble per cycle, chaining carry between nibbles.
module ula_nibble_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [3:0]           op_s,
   input  logic                 op_m,
   input  logic                 op_cin,
   input  logic [4*NIBBLES-1:0] opa,
   input  logic [4*NIBBLES-1:0] opb,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] result,
   output logic                 carry_out,
   output logic                 zero,
   output logic                 eq,
   output logic [3:0]           alu_a,
   output logic [3:0]           alu_b,
   output logic [3:0]           alu_s,
   output logic                 alu_m,
   output logic                 alu_cin,
   input  logic [3:0]           alu_f,
   input  logic                 alu_cout,
   input  logic                 alu_eq
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   // Handshake: start is a level request honoured only outside RUN; done is a
   // one-cycle pulse in DONE, and results stay stable until the next done.
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   opa_q, opb_q, acc_q, new_res;
   logic [3:0]     s_q;
   logic           m_q, carry_q, eq_acc_q;
   logic [IW-1:0]  idx_q;
   logic [3:0]     a_nib, b_nib;
   logic           accept, in_run, last;
   logic [W-1:0]   result_q;
   logic           carry_out_q, zero_q, eq_q;

   assign in_run = (state_q == S_RUN);
   assign accept = start && !in_run;
   assign last   = in_run && (idx_q == LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (idx_q == LAST) state_d = S_DONE;
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Current nibble operands, and the accumulator with this cycle's slice
   // output merged in (lower nibbles are already in place from earlier cycles).
   always_comb begin
      a_nib   = 4'h0;
      b_nib   = 4'h0;
      new_res = acc_q;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IW'(i)) begin
            a_nib              = opa_q[4*i +: 4];
            b_nib              = opb_q[4*i +: 4];
            new_res[4*i +: 4]  = alu_f;
         end
      end
   end

   always_comb begin
      busy    = in_run;
      done    = (state_q == S_DONE);
      alu_a   = 4'h0;
      alu_b   = 4'h0;
      alu_s   = 4'h0;
      alu_m   = 1'b0;
      alu_cin = 1'b0;
      if (in_run) begin
         alu_a   = a_nib;
         alu_b   = b_nib;
         alu_s   = s_q;
         alu_m   = m_q;
         alu_cin = carry_q;
      end
   end

   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign zero      = zero_q;
   assign eq        = eq_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         opa_q       <= '0;
         opb_q       <= '0;
         acc_q       <= '0;
         s_q         <= 4'h0;
         m_q         <= 1'b0;
         carry_q     <= 1'b0;
         eq_acc_q    <= 1'b0;
         idx_q       <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         zero_q      <= 1'b0;
         eq_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            opa_q    <= opa;
            opb_q    <= opb;
            s_q      <= op_s;
            m_q      <= op_m;
            carry_q  <= op_cin;
            eq_acc_q <= 1'b1;
            idx_q    <= '0;
         end else if (in_run) begin
            acc_q    <= new_res;
            carry_q  <= alu_cout;
            eq_acc_q <= eq_acc_q & alu_eq;
            idx_q    <= idx_q + IW'(1);
         end
         // Published outputs move only on the final nibble.
         if (last) begin
            result_q    <= new_res;
            carry_out_q <= m_q ? 1'b0 : alu_cout;
            zero_q      <= (new_res == '0);
            eq_q        <= eq_acc_q & alu_eq;
         end
      end
   end

endmodule
